// File: rtl/udp_mux_send_if.sv
// Bundled source-channel and GMII transmit signals of udp_mux_send.
// master: the frame builder; slave: the payload sources / MAC side.
interface udp_mux_send_if #(
    parameter int unsigned N_CH = 2
);
    logic [N_CH-1:0]    req;
    logic [16*N_CH-1:0] len;
    logic [N_CH-1:0]    rd_en;
    logic [8*N_CH-1:0]  rd_data;
    logic [47:0]        pc_mac;
    logic [31:0]        pc_ip;
    logic               gmii_txc;
    logic               gmii_tx_en;
    logic [7:0]         gmii_txd;
    logic [N_CH-1:0]    grant;
    logic               tx_done;
    logic               len_err;

    modport master (
        input  req, len, rd_data, pc_mac, pc_ip,
        output rd_en, gmii_txc, gmii_tx_en, gmii_txd, grant, tx_done, len_err
    );

    modport slave (
        output req, len, rd_data, pc_mac, pc_ip,
        input  rd_en, gmii_txc, gmii_tx_en, gmii_txd, grant, tx_done, len_err
    );
endinterface

// File: rtl/udp_mux_send.sv
// Round-robin multiplexer of N_CH byte sources into Ethernet/IPv4/UDP frames
// on a GMII transmit port, with a 2-byte channel tag ahead of the payload.
module udp_mux_send #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned MAX_LEN   = 1440,
    parameter int unsigned IFG       = 12,
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10},
    parameter logic [15:0] UDP_PORT  = 16'd1234
) (
    input logic            clk,
    input logic            rst,
    udp_mux_send_if.master bus
);
    localparam int unsigned CW       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned HDR_BITS = 336;

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_ARB  = 4'd1;
    localparam logic [3:0] S_PRE  = 4'd2;
    localparam logic [3:0] S_HEAD = 4'd3;
    localparam logic [3:0] S_TAG  = 4'd4;
    localparam logic [3:0] S_DATA = 4'd5;
    localparam logic [3:0] S_PAD  = 4'd6;
    localparam logic [3:0] S_FCS  = 4'd7;
    localparam logic [3:0] S_GAP  = 4'd8;

    logic [3:0]      state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [CW-1:0]   ch_q, ch_d;
    logic [CW-1:0]   last_q, last_d;
    logic [15:0]     len_q, len_d;
    logic [47:0]     mac_q, mac_d;
    logic [31:0]     ip_q, ip_d;
    logic [15:0]     csum_q, csum_d;
    logic [31:0]     crc_q, crc_d;
    logic            tx_en_q, tx_en_d;
    logic [7:0]      txd_q, txd_d;
    logic [N_CH-1:0] rd_en_q, rd_en_d;
    logic [N_CH-1:0] grant_q, grant_d;
    logic            tx_done_q, tx_done_d;
    logic            len_err_q, len_err_d;

    logic [15:0]         len_arr [N_CH];
    logic [7:0]          rdd_arr [N_CH];
    logic [15:0]         len_sel;
    logic [7:0]          rd_byte;
    logic [N_CH-1:0]     ch_oh;
    logic [15:0]         tot_len;
    logic [15:0]         udp_len;
    logic [HDR_BITS-1:0] hdr;
    logic [19:0]         csum_sum;
    logic [16:0]         csum_f1;
    logic [31:0]         crc_inv;
    logic                found;
    logic [CW-1:0]       idx;
    logic [CW-1:0]       pick;

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        assign len_arr[i] = bus.len[16*i +: 16];
        assign rdd_arr[i] = bus.rd_data[8*i +: 8];
    end

    assign len_sel = len_arr[ch_q];
    assign rd_byte = rdd_arr[ch_q];
    assign ch_oh   = N_CH'(1) << ch_q;
    assign tot_len = 16'd30 + len_q;
    assign udp_len = 16'd10 + len_q;
    assign crc_inv = ~crc_q;

    assign hdr = {mac_q, BOARD_MAC, 16'h0800,
                  8'h45, 8'h00, tot_len, 16'h0000, 16'h4000, 8'h80, 8'h11,
                  csum_q, BOARD_IP, ip_q,
                  UDP_PORT, UDP_PORT, udp_len, 16'h0000};

    // IPv4 header checksum from the latched frame fields; settles during PRE
    always_comb begin
        csum_sum = 20'h04500 + 20'(tot_len) + 20'h04000 + 20'h08011
                 + 20'(BOARD_IP[31:16]) + 20'(BOARD_IP[15:0])
                 + 20'(ip_q[31:16]) + 20'(ip_q[15:0]);
        csum_f1  = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
        csum_d   = ~(csum_f1[15:0] + 16'(csum_f1[16]));
    end

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Next-state, byte mux and strobes; txd/tx_en lag the state by one cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        last_d    = last_q;
        len_d     = len_q;
        mac_d     = mac_q;
        ip_d      = ip_q;
        crc_d     = crc_q;
        tx_en_d   = 1'b0;
        txd_d     = 8'h00;
        rd_en_d   = '0;
        grant_d   = grant_q;
        tx_done_d = 1'b0;
        len_err_d = 1'b0;
        found     = 1'b0;
        idx       = '0;
        pick      = last_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 16'd0;
                for (int unsigned k = 1; k <= N_CH; k++) begin
                    idx = CW'((32'(last_q) + k) % N_CH);
                    if (!found && bus.req[idx]) begin
                        found = 1'b1;
                        pick  = idx;
                    end
                end
                if (found) begin
                    ch_d    = pick;
                    grant_d = N_CH'(1) << pick;
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                if (len_sel == 16'd0 || 32'(len_sel) > MAX_LEN) begin
                    len_err_d = 1'b1;
                    last_d    = ch_q;
                    grant_d   = '0;
                    state_d   = S_IDLE;
                end else begin
                    len_d   = len_sel;
                    mac_d   = bus.pc_mac;
                    ip_d    = bus.pc_ip;
                    crc_d   = 32'hFFFF_FFFF;
                    cnt_d   = 16'd0;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                tx_en_d = 1'b1;
                txd_d   = (cnt_q == 16'd7) ? 8'hD5 : 8'h55;
                cnt_d   = cnt_q + 16'd1;
                if (cnt_q == 16'd7) begin
                    cnt_d   = 16'd0;
                    state_d = S_HEAD;
                end
            end
            S_HEAD: begin
                tx_en_d = 1'b1;
                txd_d   = hdr[9'(HDR_BITS - 1 - 8 * 32'(cnt_q)) -: 8];
                cnt_d   = cnt_q + 16'd1;
                if (cnt_q == 16'd41) begin
                    cnt_d   = 16'd0;
                    state_d = S_TAG;
                end
            end
            S_TAG: begin
                // rd_en runs two slots ahead: one for the source, one for this register stage
                tx_en_d = 1'b1;
                txd_d   = (cnt_q == 16'd0) ? 8'h00 : 8'(ch_q);
                rd_en_d = (cnt_q == 16'd0 || len_q >= 16'd2) ? ch_oh : '0;
                cnt_d   = cnt_q + 16'd1;
                if (cnt_q == 16'd1) begin
                    cnt_d   = 16'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                tx_en_d = 1'b1;
                txd_d   = rd_byte;
                rd_en_d = (32'(cnt_q) + 32'd2 < 32'(len_q)) ? ch_oh : '0;
                cnt_d   = cnt_q + 16'd1;
                if (cnt_q == len_q - 16'd1) begin
                    cnt_d   = 16'd0;
                    state_d = (len_q < 16'd16) ? S_PAD : S_FCS;
                end
            end
            S_PAD: begin
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + 16'd1;
                if (cnt_q == 16'd15 - len_q) begin
                    cnt_d   = 16'd0;
                    state_d = S_FCS;
                end
            end
            S_FCS: begin
                tx_en_d = 1'b1;
                case (cnt_q[1:0])
                    2'd0:    txd_d = crc_inv[7:0];
                    2'd1:    txd_d = crc_inv[15:8];
                    2'd2:    txd_d = crc_inv[23:16];
                    default: txd_d = crc_inv[31:24];
                endcase
                cnt_d = cnt_q + 16'd1;
                if (cnt_q == 16'd3) begin
                    cnt_d   = 16'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                tx_done_d = (cnt_q == 16'd0);
                cnt_d     = cnt_q + 16'd1;
                if (cnt_q == 16'(IFG - 1)) begin
                    cnt_d   = 16'd0;
                    last_d  = ch_q;
                    grant_d = '0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase

        if (state_q == S_HEAD || state_q == S_TAG || state_q == S_DATA || state_q == S_PAD) begin
            crc_d = crc_byte(crc_q, txd_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            ch_q      <= '0;
            last_q    <= CW'(N_CH - 1);
            len_q     <= 16'd0;
            mac_q     <= 48'd0;
            ip_q      <= 32'd0;
            csum_q    <= 16'd0;
            crc_q     <= 32'hFFFF_FFFF;
            tx_en_q   <= 1'b0;
            txd_q     <= 8'h00;
            rd_en_q   <= '0;
            grant_q   <= '0;
            tx_done_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
            len_q     <= len_d;
            mac_q     <= mac_d;
            ip_q      <= ip_d;
            csum_q    <= csum_d;
            crc_q     <= crc_d;
            tx_en_q   <= tx_en_d;
            txd_q     <= txd_d;
            rd_en_q   <= rd_en_d;
            grant_q   <= grant_d;
            tx_done_q <= tx_done_d;
            len_err_q <= len_err_d;
        end
    end

    assign bus.gmii_txc   = clk;
    assign bus.gmii_tx_en = tx_en_q;
    assign bus.gmii_txd   = txd_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.grant      = grant_q;
    assign bus.tx_done    = tx_done_q;
    assign bus.len_err    = len_err_q;
endmodule

// File: tb/tb_udp_mux_send.sv
// Directed bench for udp_mux_send: frame contents against a byte-level model,
// arbitration order, length rejection, padding and mid-frame reset.
module tb_udp_mux_send;
    localparam int unsigned N_CH = 2;
    localparam int          IFG  = 12;
    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = 32'hC0A8_010A;
    localparam logic [47:0] MAC_A = 48'hA0_B1_C2_D3_E4_F5;
    localparam logic [31:0] IP_A  = 32'h0A00_0001;
    localparam logic [47:0] MAC_B = 48'hFF_EE_DD_CC_BB_AA;
    localparam logic [31:0] IP_B  = 32'h0102_0304;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    udp_mux_send_if #(.N_CH(N_CH)) bus ();
    udp_mux_send #(.N_CH(N_CH)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_checks = 0;
    int n_err    = 0;

    int src_cnt [N_CH] = '{default: 0};
    int rd_cnt  [N_CH] = '{default: 0};
    int done_cnt = 0, err_cnt = 0, bad_idle = 0, bad_rd = 0, bad_grant = 0;
    int min_gap = 1000000, idle_run = 0;
    bit prev_en = 1'b0, seen_fall = 1'b0;
    logic [7:0]      cap_q [$];
    logic [7:0]      exp_q [$];
    logic [N_CH-1:0] grant_log [$];

    function automatic logic [7:0] src_byte(input int ch, input int k);
        return 8'((k * 7 + ch * 16 + 3) % 256);
    endfunction

    // payload sources: byte valid the cycle after its rd_en
    always @(posedge clk) begin
        for (int i = 0; i < int'(N_CH); i++) begin
            if (bus.rd_en[i]) begin
                bus.rd_data[8*i +: 8] <= src_byte(i, src_cnt[i]);
                src_cnt[i] <= src_cnt[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.gmii_tx_en) cap_q.push_back(bus.gmii_txd);
        if (!bus.gmii_tx_en && bus.gmii_txd !== 8'h00) bad_idle++;
        if (bus.tx_done) done_cnt++;
        if (bus.len_err) err_cnt++;
        for (int i = 0; i < int'(N_CH); i++) if (bus.rd_en[i]) rd_cnt[i]++;
        if ((bus.rd_en & ~bus.grant) != '0) bad_rd++;
        if ($countones(bus.grant) > 1) bad_grant++;
        if (bus.gmii_tx_en) begin
            if (!prev_en) begin
                if (seen_fall && idle_run < min_gap) min_gap = idle_run;
                grant_log.push_back(bus.grant);
            end
            idle_run = 0;
        end else begin
            if (prev_en) seen_fall = 1'b1;
            idle_run++;
        end
        prev_en = bus.gmii_tx_en;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_crc(input logic [7:0] q [$], input int from, input int to);
        logic [31:0] c;
        logic        fb;
        logic [7:0]  b;
        c = 32'hFFFF_FFFF;
        for (int i = from; i <= to; i++) begin
            b = q[i];
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ b[j];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic build_exp(input int ch, input int n, input logic [47:0] mac,
                             input logic [31:0] ip, input int s0);
        logic [7:0]  b [$];
        logic [47:0] bm;
        logic [31:0] bi;
        logic [15:0] tot, ul, cs;
        logic [31:0] c;
        int          sum;
        bm  = BOARD_MAC;
        bi  = BOARD_IP;
        tot = 16'(30 + n);
        ul  = 16'(10 + n);
        for (int i = 5; i >= 0; i--) b.push_back(mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) b.push_back(bm[8*i +: 8]);
        b.push_back(8'h08); b.push_back(8'h00);
        b.push_back(8'h45); b.push_back(8'h00); b.push_back(tot[15:8]); b.push_back(tot[7:0]);
        b.push_back(8'h00); b.push_back(8'h00); b.push_back(8'h40); b.push_back(8'h00);
        b.push_back(8'h80); b.push_back(8'h11); b.push_back(8'h00); b.push_back(8'h00);
        for (int i = 3; i >= 0; i--) b.push_back(bi[8*i +: 8]);
        for (int i = 3; i >= 0; i--) b.push_back(ip[8*i +: 8]);
        b.push_back(8'h04); b.push_back(8'hD2); b.push_back(8'h04); b.push_back(8'hD2);
        b.push_back(ul[15:8]); b.push_back(ul[7:0]); b.push_back(8'h00); b.push_back(8'h00);
        b.push_back(8'h00); b.push_back(8'(ch));
        for (int k = 0; k < n; k++) b.push_back(src_byte(ch, s0 + k));
        while (b.size() - 42 < 18) b.push_back(8'h00);
        sum = 0;
        for (int i = 14; i < 34; i += 2) sum += int'({b[i], b[i+1]});
        while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
        cs    = ~16'(sum);
        b[24] = cs[15:8];
        b[25] = cs[7:0];
        c = ref_crc(b, 0, b.size() - 1);
        exp_q.delete();
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        foreach (b[i]) exp_q.push_back(b[i]);
        for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
    endtask

    task automatic check_frame(input string tag, input int ch, input int n, input logic [47:0] mac,
                               input logic [31:0] ip, input int s0);
        int mism;
        int sz;
        build_exp(ch, n, mac, ip, s0);
        check({tag, "_size"}, 64'(cap_q.size()), 64'(exp_q.size()));
        mism = (cap_q.size() > exp_q.size()) ? cap_q.size() - exp_q.size() : exp_q.size() - cap_q.size();
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            if (cap_q[i] !== exp_q[i]) mism++;
        check({tag, "_bytes"}, 64'(mism), 64'd0);
        sz = cap_q.size();
        if (sz >= 12)
            check({tag, "_fcs"}, 64'({cap_q[sz-1], cap_q[sz-2], cap_q[sz-3], cap_q[sz-4]}),
                  64'(ref_crc(cap_q, 8, sz - 5)));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        int k;
        start = done_cnt;
        k = 0;
        while (done_cnt == start && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 64'(done_cnt != start), 64'd1);
    endtask

    task automatic err_req(input string tag, input logic [15:0] l0);
        bus.len[15:0] = l0;
        bus.req = 2'b01;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_arb_grant"}, 64'(bus.grant), 64'd1);
        bus.req = 2'b00;
        @(posedge clk);
        #1;
        check({tag, "_len_err"}, 64'(bus.len_err), 64'd1);
        check({tag, "_grant_off"}, 64'(bus.grant), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 64'(bus.len_err), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int s0, rd0, rd1, d0, e0, nz, ch;
        bus.req    = '0;
        bus.len    = '0;
        bus.pc_mac = MAC_A;
        bus.pc_ip  = IP_A;
        repeat (3) @(negedge clk);
        check("rst_tx_en",   64'(bus.gmii_tx_en), 64'd0);
        check("rst_txd",     64'(bus.gmii_txd),   64'd0);
        check("rst_rd_en",   64'(bus.rd_en),      64'd0);
        check("rst_grant",   64'(bus.grant),      64'd0);
        check("rst_tx_done", 64'(bus.tx_done),    64'd0);
        check("rst_len_err", 64'(bus.len_err),    64'd0);
        rst = 1'b0;
        @(negedge clk);

        // 100-byte frame on channel 0, inputs disturbed mid-frame
        s0 = src_cnt[0]; rd0 = rd_cnt[0]; rd1 = rd_cnt[1]; d0 = done_cnt;
        cap_q.delete();
        bus.len[15:0] = 16'd100;
        bus.req = 2'b01;
        @(posedge clk);
        @(negedge clk);
        check("t1_arb_grant", 64'(bus.grant), 64'd1);
        check("t1_arb_txen",  64'(bus.gmii_tx_en), 64'd0);
        @(posedge clk);
        #1;
        check("t1_e1_txen", 64'(bus.gmii_tx_en), 64'd0);
        @(posedge clk);
        #1;
        check("t1_pre_en",   64'(bus.gmii_tx_en), 64'd1);
        check("t1_pre_byte", 64'(bus.gmii_txd),   64'h55);
        bus.req = 2'b00;
        bus.len[15:0] = 16'd7;
        bus.pc_mac = MAC_B;
        bus.pc_ip  = IP_B;
        wait_done("t1", 400);
        repeat (IFG + 8) @(negedge clk);
        check("t1_done_once", 64'(done_cnt - d0), 64'd1);
        check_frame("t1", 0, 100, MAC_A, IP_A, s0);
        check("t1_totlen", 64'({cap_q[24], cap_q[25]}), 64'd130);
        check("t1_udplen", 64'({cap_q[46], cap_q[47]}), 64'd110);
        check("t1_rd0", 64'(rd_cnt[0] - rd0), 64'd100);
        check("t1_rd1", 64'(rd_cnt[1] - rd1), 64'd0);
        bus.pc_mac = MAC_A;
        bus.pc_ip  = IP_A;

        // rejected lengths, then channel 1 is next
        e0 = err_cnt;
        cap_q.delete();
        err_req("t4_len0", 16'd0);
        err_req("t4_len2000", 16'd2000);
        check("t4_err_count", 64'(err_cnt - e0), 64'd2);
        check("t4_no_tx", 64'(cap_q.size()), 64'd0);
        s0 = src_cnt[1];
        bus.len = {16'd5, 16'd2000};
        bus.req = 2'b11;
        @(posedge clk);
        @(negedge clk);
        check("t4_grant_ch1", 64'(bus.grant), 64'd2);
        bus.req = 2'b00;
        wait_done("t4b", 300);
        check_frame("t4b", 1, 5, MAC_A, IP_A, s0);
        check("t4_err_after", 64'(err_cnt - e0), 64'd2);
        repeat (IFG + 8) @(negedge clk);

        // 1-byte payload padded to minimum frame
        s0 = src_cnt[0]; rd0 = rd_cnt[0];
        cap_q.delete();
        bus.len = {16'd5, 16'd1};
        bus.req = 2'b01;
        @(posedge clk);
        @(negedge clk);
        check("t3_grant", 64'(bus.grant), 64'd1);
        bus.req = 2'b00;
        wait_done("t3", 300);
        check_frame("t3", 0, 1, MAC_A, IP_A, s0);
        check("t3_frame64", 64'(cap_q.size() - 8), 64'd64);
        check("t3_totlen", 64'({cap_q[24], cap_q[25]}), 64'd31);
        nz = 0;
        for (int i = 53; i <= 67; i++) if (cap_q[i] !== 8'h00) nz++;
        check("t3_pad_zero", 64'(nz), 64'd0);
        check("t3_rd0", 64'(rd_cnt[0] - rd0), 64'd1);
        repeat (IFG + 8) @(negedge clk);

        // reset in the middle of a 500-byte payload
        rd0 = rd_cnt[0]; d0 = done_cnt;
        bus.len[15:0] = 16'd500;
        bus.req = 2'b01;
        @(posedge clk);
        @(negedge clk);
        bus.req = 2'b00;
        repeat (110) @(negedge clk);
        check("t5_in_data", 64'((rd_cnt[0] - rd0) > 0 && (rd_cnt[0] - rd0) < 500), 64'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_txen",  64'(bus.gmii_tx_en), 64'd0);
        check("t5_rst_txd",   64'(bus.gmii_txd),   64'd0);
        check("t5_rst_rd_en", 64'(bus.rd_en),      64'd0);
        check("t5_rst_grant", 64'(bus.grant),      64'd0);
        @(negedge clk);
        rst = 1'b0;
        cap_q.delete();
        repeat (20) @(negedge clk);
        check("t5_quiet", 64'(cap_q.size()), 64'd0);
        check("t5_no_done", 64'(done_cnt - d0), 64'd0);

        // both channels held: alternation from channel 0 after reset
        grant_log.delete();
        bus.len = {16'd30, 16'd20};
        bus.req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            ch = f % 2;
            s0 = src_cnt[ch];
            wait_done($sformatf("t2_f%0d", f), 400);
            check_frame($sformatf("t2_f%0d", f), ch, (ch == 1) ? 30 : 20, MAC_A, IP_A, s0);
            cap_q.delete();
        end
        bus.req = 2'b00;
        repeat (IFG + 8) @(negedge clk);
        check("t2_log_size", 64'(grant_log.size()), 64'd4);
        for (int f = 0; f < 4; f++)
            check($sformatf("t2_grant%0d", f), 64'(grant_log[f]), (f % 2 == 0) ? 64'd1 : 64'd2);
        check("t2_min_gap", 64'(min_gap >= 12), 64'd1);
        check("idle_txd_zero", 64'(bad_idle), 64'd0);
        check("rd_en_granted", 64'(bad_rd), 64'd0);
        check("grant_onehot", 64'(bad_grant), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/udp_mux_send.md
UDP_MUX_SEND -- requirements
Module: udp_mux_send

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of payload source channels (1..4).
REQ-002 SHALL have parameter MAX_LEN, default 1440: maximum payload bytes per frame.
REQ-003 SHALL have parameter IFG, default 12: idle cycles between frames (minimum 12).
REQ-004 SHALL have parameter BOARD_MAC, default 48'h00_11_22_33_44_55: source MAC.
REQ-005 SHALL have parameter BOARD_IP, default 192.168.1.10: source IP.
REQ-006 SHALL have parameter UDP_PORT, default 1234: source and destination UDP port.
REQ-007 SHALL have port clk, input, 1: single clock for all logic; also drives gmii_txc.
REQ-008 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-009 SHALL have port req, input, N_CH: per-channel frame request, level.
REQ-010 SHALL have port len, input, 16*N_CH: per-channel payload byte count, channel i at [16i+15:16i].
REQ-011 SHALL have port rd_en, output, N_CH: per-channel byte read strobe.
REQ-012 SHALL have port rd_data, input, 8*N_CH: per-channel byte, valid one cycle after rd_en.
REQ-013 SHALL have port pc_mac, input, 48: destination MAC.
REQ-014 SHALL have port pc_ip, input, 32: destination IP.
REQ-015 SHALL have port gmii_txc, output, 1: equal to clk.
REQ-016 SHALL have port gmii_tx_en, output, 1: frame byte valid.
REQ-017 SHALL have port gmii_txd, output, 8: frame byte.
REQ-018 SHALL have port grant, output, N_CH: one-hot channel being served; zero when idle.
REQ-019 SHALL have port tx_done, output, 1: one-cycle pulse after the last FCS byte.
REQ-020 SHALL have port len_err, output, 1: one-cycle pulse on a rejected request.

Function
REQ-021 SHALL implement states IDLE, ARB, PRE, HEAD, TAG, DATA, PAD, FCS, GAP.
REQ-022 IDLE->ARB SHALL occur when any req bit is high.
REQ-023 ARB SHALL pick a channel round-robin, starting after the last served channel; after reset the search starts at channel 0.
REQ-024 ARB SHALL latch the chosen channel's len, pc_mac and pc_ip for the whole frame.
REQ-025 If the latched len is 0 or > MAX_LEN, ARB SHALL pulse len_err, mark that channel served, and return to IDLE with no frame sent.
REQ-026 The first preamble byte SHALL appear on gmii_txd with gmii_tx_en=1 exactly two cycles after the edge that samples req in IDLE.
REQ-027 PRE SHALL send seven 0x55 bytes, then 0xD5.
REQ-028 HEAD SHALL send 42 bytes, in order:
- MAC: pc_mac, BOARD_MAC, type 0x0800.
- IPv4: 0x45, 0x00, total length = 30+len, id 0, flags/frag 0x4000, TTL 0x80, protocol 17, header checksum, BOARD_IP, pc_ip.
- UDP: UDP_PORT, UDP_PORT, UDP length = 10+len, checksum 0.
REQ-029 The IP header checksum SHALL be the one's complement of the end-around-carry sum of the header 16-bit words with the checksum field taken as zero; it SHALL be computed before HEAD starts.
REQ-030 TAG SHALL send 2 bytes: 0x00 followed by the channel index.
REQ-031 DATA SHALL send exactly len bytes from the granted channel's rd_data.
REQ-032 rd_en SHALL be asserted for exactly len cycles, on the granted channel only, with each assertion one cycle before its byte goes out.
REQ-033 PAD SHALL send 0x00 bytes until 2+len reaches 18; it is skipped when 2+len >= 18.
REQ-034 FCS SHALL send the IEEE 802.3 CRC-32 over all bytes from the destination MAC through PAD: initial value 0xFFFFFFFF, reflected, final inversion, least significant byte first.
REQ-035 gmii_tx_en SHALL be 1 continuously from the first preamble byte through the last FCS byte; gmii_txd SHALL be 0x00 whenever gmii_tx_en=0.
REQ-036 After FCS the block SHALL pulse tx_done on the next cycle, spend IFG cycles in GAP with gmii_tx_en=0, then return to IDLE.
REQ-037 Changes on req, len, pc_mac or pc_ip while a frame is being sent SHALL not affect that frame.
REQ-038 grant SHALL be one-hot from ARB through GAP and zero otherwise.

Reset
REQ-039 While rst=1, all of the following SHALL hold:
- State is IDLE.
- gmii_tx_en=0, gmii_txd=0x00, rd_en=0, grant=0, tx_done=0, len_err=0.
- The round-robin pointer selects channel 0 next.
REQ-040 Reset asserted mid-frame SHALL abort the frame at once; no FCS is sent and the first frame after release starts from PRE.

Verification
REQ-041 N_CH=2, req=01, len0=100 -> frame of 8+42+2+100+4=156 bytes; IP total length=130; UDP length=110; FCS matches a reference CRC; tx_done pulses once.
REQ-042 req=11 held across 4 frames -> grant sequence 01,10,01,10; at least 12 idle cycles between gmii_tx_en pulses.
REQ-043 len0=1 -> 15 bytes of 0x00 pad after the data byte; frame is 64 bytes excluding preamble; IP total length=31.
REQ-044 len0=0, then len0=2000 -> len_err pulses each time; no gmii_tx_en activity; channel 1 is served next if it is requesting.
REQ-045 rst pulsed during DATA of a len=500 frame -> outputs 0 within the reset cycle; next request produces a complete, valid frame.
